zacore_inst_encoder: RTL and testbench

ZACORE_INST_ENCODER -- requirements
Module: zacore_inst_encoder

---
 rtl/zacore_inst_encoder.sv | 137 +++++++++++++
 tb/tb_zacore_inst_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zacore_inst_encoder.sv
// RV32 instruction encoder: packs fields + immediate into a 32-bit word,
// flags unrepresentable immediates, buffers results in a 2-entry FIFO.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake
//   in_fmt                0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                         instruction fields
//   out_valid / out_ready result handshake
//   out_inst, out_err     FIFO head: encoded word and error flag
//   cnt_ok, cnt_err       saturating counts of delivered words
module zacore_inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);

    logic [31:0] w_inst;
    logic [31:0] w_word;
    logic        w_err;
    logic        w_fit12;
    logic        w_fit13;
    logic        w_fit21;
    logic        w_push;
    logic        w_pop;

    logic [31:0] r_mem_inst [2];
    logic        r_mem_err  [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_occ;
    logic [15:0] r_cnt_ok;
    logic [15:0] r_cnt_err;

    // A signed value fits in N bits when all bits from N-1 up are equal.
    assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_inst = 32'h0;
        w_err  = 1'b0;
        unique case (in_fmt)
            3'd0: w_inst = {in_funct7, in_rs2, in_rs1, in_funct3,
                            in_rd, in_opcode};
            3'd1: begin
                w_inst = {in_imm[11:0], in_rs1, in_funct3,
                          in_rd, in_opcode};
                w_err  = ~w_fit12;
            end
            3'd2: begin
                w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:0], in_opcode};
                w_err  = ~w_fit12;
            end
            3'd3: begin
                w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                          in_funct3, in_imm[4:1], in_imm[11],
                          in_opcode};
                w_err  = in_imm[0] | ~w_fit13;
            end
            3'd4: begin
                w_inst = {in_imm[31:12], in_rd, in_opcode};
                w_err  = |in_imm[11:0];
            end
            3'd5: begin
                w_inst = {in_imm[20], in_imm[10:1], in_imm[11],
                          in_imm[19:12], in_rd, in_opcode};
                w_err  = in_imm[0] | ~w_fit21;
            end
            default: w_err = 1'b1;
        endcase
    end

    // Failed encodings are stored as an all-zero word.
    assign w_word = w_err ? 32'h0 : w_inst;

    assign in_ready  = (r_occ < 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_inst  = r_mem_inst[r_rptr];
    assign out_err   = r_mem_err[r_rptr];
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

    // Storage is not reset; it is only visible behind out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= w_word;
            r_mem_err[r_wptr]  <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_occ     <= 2'd0;
            r_cnt_ok  <= 16'h0;
            r_cnt_err <= 16'h0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            if (w_push & ~w_pop)
                r_occ <= r_occ + 2'd1;
            else if (w_pop & ~w_push)
                r_occ <= r_occ - 2'd1;
            if (w_pop) begin
                if (out_err) begin
                    if (r_cnt_err != 16'hFFFF)
                        r_cnt_err <= r_cnt_err + 16'd1;
                end else begin
                    if (r_cnt_ok != 16'hFFFF)
                        r_cnt_ok <= r_cnt_ok + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zacore_inst_encoder.sv
// Bench for zacore_inst_encoder: fixed vectors, handshake corner cases,
// randomized traffic against a queue-based reference, counter saturation.
module tb_zacore_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    int n_run  = 0;
    int n_fail = 0;

    logic [32:0] q[$];
    int          m_ok;
    int          m_err;

    zacore_inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .cnt_ok    (cnt_ok),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoder from the field/immediate placement rules.
    function automatic logic [32:0] ref_enc(
        input logic [2:0] f, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        longint s;
        logic [31:0] x;
        logic [31:0] b;
        bit e;
        s = longint'($signed(imm));
        b = 32'(op);
        x = 32'h0;
        e = 1'b0;
        case (f)
            3'd0: x = b | (32'(rd) << 7) | (32'(f3) << 12)
                    | (32'(rs1) << 15) | (32'(rs2) << 20)
                    | (32'(f7) << 25);
            3'd1: begin
                x = b | (32'(rd) << 7) | (32'(f3) << 12)
                  | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                x = b | ((imm & 32'h1F) << 7) | (32'(f3) << 12)
                  | (32'(rs1) << 15) | (32'(rs2) << 20)
                  | (((imm >> 5) & 32'h7F) << 25);
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                x = b | (((imm >> 11) & 32'h1) << 7)
                  | (((imm >> 1) & 32'hF) << 8) | (32'(f3) << 12)
                  | (32'(rs1) << 15) | (32'(rs2) << 20)
                  | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 12) & 32'h1) << 31);
                e = (s % 2 != 0) || (s < -4096) || (s > 4094);
            end
            3'd4: begin
                x = b | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
                e = (imm % 4096) != 0;
            end
            3'd5: begin
                x = b | (32'(rd) << 7)
                  | (((imm >> 12) & 32'hFF) << 12)
                  | (((imm >> 11) & 32'h1) << 20)
                  | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 20) & 32'h1) << 31);
                e = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
            end
            default: e = 1'b1;
        endcase
        if (e) x = 32'h0;
        return {e, x};
    endfunction

    task automatic check_state();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_inst", out_inst, q[0][31:0]);
            chk("out_err", 32'(out_err), 32'(q[0][32]));
        end
        chk("cnt_ok", 32'(cnt_ok), 32'(m_ok));
        chk("cnt_err", 32'(cnt_err), 32'(m_err));
    endtask

    // One clock of the reference queue, then compare at the next negedge.
    task automatic tick(input bit ovr, input logic [32:0] v,
                        output bit acc);
        logic [32:0] pv;
        bit          pop;
        pv  = ovr ? v : ref_enc(in_fmt, in_opcode, in_rd, in_rs1,
                                in_rs2, in_funct3, in_funct7, in_imm);
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        if (pop) begin
            if (q[0][32]) begin
                if (m_err < 65535) m_err++;
            end else begin
                if (m_ok < 65535) m_ok++;
            end
            void'(q.pop_front());
        end
        if (acc) q.push_back(pv);
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic set_f(input vec_t t);
        in_fmt    = t.fmt;
        in_opcode = t.op;
        in_rd     = t.rd;
        in_rs1    = t.rs1;
        in_rs2    = t.rs2;
        in_funct3 = t.f3;
        in_funct7 = t.f7;
        in_imm    = t.imm;
    endtask

    task automatic rand_f();
        int bnd[17];
        bnd = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                4096, -1048577, -1048576, 1048574, 1048575, 1048576,
                0, 1, 2};
        in_fmt    = 3'($urandom_range(0, 7));
        in_opcode = 7'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: in_imm = 32'(bnd[$urandom_range(0, 16)]);
            2: in_imm = $urandom & 32'hFFFF_F000;
            default: in_imm = $urandom;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        m_ok  = 0;
        m_err = 0;
        rst_n = 1'b1;
    endtask

    vec_t tab[14];
    bit   acc;
    int   naccs;

    initial begin
        tab[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd5, 32'h0050_0093, 1'b0};
        tab[1]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        tab[2]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd2048, 32'h0010_00EF, 1'b0};
        tab[3]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd2048, 32'h0, 1'b1};
        tab[4]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd3, 32'h0, 1'b1};
        tab[5]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1001, 32'h0, 1'b1};
        tab[6]  = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd0, 32'h0, 1'b1};
        tab[7]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
                    32'h1234_5677, 32'h0020_81B3, 1'b0};
        tab[8]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,
                    32'd8, 32'h0020_A423, 1'b0};
        tab[9]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1234_5000, 32'h1234_52B7, 1'b0};
        tab[10] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'hFFFF_F800, 32'h8000_0093, 1'b0};
        tab[11] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd4094, 32'h7E00_0FE3, 1'b0};
        tab[12] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'hFFF0_0000, 32'h8000_00EF, 1'b0};
        tab[13] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd0, 32'h0, 1'b1};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_f(tab[0]);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        check_state();

        // Fixed vectors, one per cycle with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_f(tab[i]);
            in_valid = 1'b1;
            tick(1'b1, {tab[i].err, tab[i].inst}, acc);
        end
        in_valid = 1'b0;
        tick(1'b0, 33'h0, acc);
        tick(1'b0, 33'h0, acc);

        // Stalled consumer: third request must wait for space.
        out_ready = 1'b0;
        naccs = 0;
        for (int i = 0; i < 3; i++) begin
            set_f(tab[7 + i]);
            in_valid = 1'b1;
            tick(1'b0, 33'h0, acc);
            if (acc) naccs++;
        end
        chk("stall_accepts", 32'(naccs), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && naccs < 3; k++) begin
            tick(1'b0, 33'h0, acc);
            if (acc) naccs++;
        end
        in_valid = 1'b0;
        repeat (3) tick(1'b0, 33'h0, acc);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_f();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            tick(1'b0, 33'h0, acc);
        end

        // Occupancy 1 with simultaneous push and pop, then async reset.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick(1'b0, 33'h0, acc);
        set_f(tab[0]);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick(1'b0, 33'h0, acc);
        set_f(tab[2]);
        out_ready = 1'b1;
        tick(1'b0, 33'h0, acc);
        chk("occ1_depth", 32'(q.size()), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        chk("rst_cnt_err", 32'(cnt_err), 32'd0);
        @(negedge clk);
        do_reset();
        check_state();

        // Counter saturation.
        set_f(tab[0]);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_ok_65535", 32'(cnt_ok), 32'hFFFF);
        chk("cnt_err_zero", 32'(cnt_err), 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_ok_sat", 32'(cnt_ok), 32'hFFFF);
        chk("sat_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
